vd_acs_sched: RTL and testbench

- Sequencer that time-shares a bank of NUM_BFLY BMC/ACS butterfly units across all trellis states of the Viterbi decoder (K=7, 64 states).
- Per received symbol pair:
  - steps the butterfly-group index;
  - selects the ping-pong path-metric banks;
  - tracks the minimum new path metric and schedules metric normalization;
  - addresses survivor memory.
- After every FRAME_LEN symbols it requests a traceback.
- Sits between the symbol input stream and the BMC/ACS array / survivor RAM.

---
 rtl/vd_acs_sched.sv | 128 ++++++++++++
 tb/tb_vd_acs_sched.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vd_acs_sched.sv
// Viterbi ACS scheduler: time-shares NUM_BFLY butterflies over all trellis states,
// ping-pongs metric banks, schedules normalization and requests traceback per frame.
module vd_acs_sched #(
  parameter int unsigned NUM_STATES  = 64,
  parameter int unsigned NUM_BFLY    = 8,
  parameter int unsigned PM_W        = 8,
  parameter int unsigned NORM_THRESH = 128,
  parameter int unsigned FRAME_LEN   = 32,
  localparam int unsigned G  = NUM_STATES / (2 * NUM_BFLY),
  localparam int unsigned GW = (G > 1) ? $clog2(G) : 1,
  localparam int unsigned FW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_pair,
  output logic [1:0]      rx_pair,
  output logic            acs_en,
  output logic [GW-1:0]   grp_idx,
  output logic            pm_rd_bank,
  input  logic [PM_W-1:0] min_pm,
  output logic            norm_en,
  output logic [PM_W-1:0] norm_sub,
  output logic            surv_wr_en,
  output logic [FW-1:0]   surv_wr_addr,
  output logic            tb_req,
  input  logic            tb_ack
);

  typedef enum logic [1:0] {StIdle, StRun, StUpd, StTbReq} state_e;

  state_e          state_q, state_d;
  logic [1:0]      rx_pair_q;
  logic [GW-1:0]   grp_q;
  logic [PM_W-1:0] run_min_q;
  logic            pm_rd_bank_q;
  logic [FW-1:0]   sym_cnt_q;
  logic            norm_en_q;
  logic [PM_W-1:0] norm_sub_q;

  logic            grp_last;
  logic            frame_last;
  logic            norm_hit;

  assign grp_last   = (grp_q == GW'(G - 1));
  assign frame_last = (sym_cnt_q == FW'(FRAME_LEN - 1));
  assign norm_hit   = (32'(run_min_q) >= NORM_THRESH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (in_valid) state_d = StRun;
      StRun:   if (grp_last) state_d = StUpd;
      StUpd:   state_d = frame_last ? StTbReq : StIdle;
      StTbReq: if (tb_ack) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // run_min already folds in the last group's min_pm by the time UPD is reached.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_pair_q    <= '0;
      grp_q        <= '0;
      run_min_q    <= '1;
      pm_rd_bank_q <= 1'b0;
      sym_cnt_q    <= '0;
      norm_en_q    <= 1'b0;
      norm_sub_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            rx_pair_q <= in_pair;
            grp_q     <= '0;
            run_min_q <= '1;
          end
        end
        StRun: begin
          grp_q <= grp_q + GW'(1);
          if (min_pm < run_min_q) run_min_q <= min_pm;
        end
        StUpd: begin
          pm_rd_bank_q <= ~pm_rd_bank_q;
          norm_en_q    <= norm_hit;
          norm_sub_q   <= norm_hit ? run_min_q : '0;
          sym_cnt_q    <= frame_last ? '0 : sym_cnt_q + FW'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    in_ready     = 1'b0;
    acs_en       = 1'b0;
    surv_wr_en   = 1'b0;
    grp_idx      = '0;
    surv_wr_addr = '0;
    tb_req       = 1'b0;
    unique case (state_q)
      StIdle: in_ready = 1'b1;
      StRun: begin
        acs_en       = 1'b1;
        surv_wr_en   = 1'b1;
        grp_idx      = grp_q;
        surv_wr_addr = sym_cnt_q;
      end
      StTbReq: tb_req = 1'b1;
      default: ;
    endcase
  end

  assign rx_pair    = rx_pair_q;
  assign pm_rd_bank = pm_rd_bank_q;
  assign norm_en    = norm_en_q;
  assign norm_sub   = norm_sub_q;

endmodule

// File: tb/tb_vd_acs_sched.sv
// Self-checking bench for vd_acs_sched: table vectors, hand-written corner sequences and
// randomized symbols checked against a per-symbol transaction model.
module tb_vd_acs_sched;

  localparam int G         = 4;
  localparam int FRAME_LEN = 32;
  localparam int THRESH    = 128;

  typedef logic [3:0][7:0] mins_t;
  typedef struct {
    logic [1:0] pair;
    mins_t      mins;
    logic       en;
    logic [7:0] sub;
  } vec_t;

  logic       clk, rst_n;
  logic       in_valid, in_ready;
  logic [1:0] in_pair, rx_pair;
  logic       acs_en;
  logic [1:0] grp_idx;
  logic       pm_rd_bank;
  logic [7:0] min_pm;
  logic       norm_en;
  logic [7:0] norm_sub;
  logic       surv_wr_en;
  logic [4:0] surv_wr_addr;
  logic       tb_req, tb_ack;

  vd_acs_sched dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_pair      (in_pair),
    .rx_pair      (rx_pair),
    .acs_en       (acs_en),
    .grp_idx      (grp_idx),
    .pm_rd_bank   (pm_rd_bank),
    .min_pm       (min_pm),
    .norm_en      (norm_en),
    .norm_sub     (norm_sub),
    .surv_wr_en   (surv_wr_en),
    .surv_wr_addr (surv_wr_addr),
    .tb_req       (tb_req),
    .tb_ack       (tb_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Transaction-level model: symbols since reset, read bank, pending normalization.
  int         m_sym;
  logic       m_bank;
  logic       m_norm_en;
  logic [7:0] m_norm_sub;
  bit         b2b_chk;
  bit         have_last;
  time        last_acc;

  vec_t tbl [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_sym      = 0;
    m_bank     = 1'b0;
    m_norm_en  = 1'b0;
    m_norm_sub = 8'd0;
    have_last  = 1'b0;
  endtask

  function automatic mins_t mk(input int a, input int b, input int c, input int d);
    mins_t m;
    m[0] = 8'(a);
    m[1] = 8'(b);
    m[2] = 8'(c);
    m[3] = 8'(d);
    return m;
  endfunction

  // Called at a negedge. Offers one pair, follows it through RUN/UPD (and TBREQ at frame end).
  task automatic run_symbol(input logic [1:0] pair, input mins_t mins, input bit hold,
                            input bit spur, input int ack_dly);
    int         waited;
    logic [7:0] lo;
    bit         fe;
    waited   = 0;
    in_pair  = pair;
    in_valid = 1'b1;
    while (in_ready !== 1'b1) begin
      @(negedge clk);
      waited++;
      if (waited > 50) begin
        n_cmp++;
        n_err++;
        $display("FAIL accept_timeout: in_ready never rose within 50 cycles");
        in_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    if (b2b_chk && have_last) chk("throughput_cycles", ($time - last_acc) / 10, G + 2);
    last_acc  = $time;
    have_last = 1'b1;
    #1;
    in_valid = hold;
    in_pair  = ~pair;
    lo = 8'hff;
    for (int k = 0; k < G; k++) begin
      @(negedge clk);
      chk("run_acs_en", acs_en, 1);
      chk("run_surv_wr_en", surv_wr_en, 1);
      chk("run_grp_idx", grp_idx, k);
      chk("run_surv_addr", surv_wr_addr, m_sym % FRAME_LEN);
      chk("run_in_ready", in_ready, 0);
      chk("run_rx_pair", rx_pair, pair);
      chk("run_bank", pm_rd_bank, m_bank);
      chk("run_norm_en", norm_en, m_norm_en);
      chk("run_norm_sub", norm_sub, m_norm_sub);
      chk("run_tb_req", tb_req, 0);
      min_pm = mins[k];
      if (mins[k] < lo) lo = mins[k];
      tb_ack = spur ? 1'($urandom) : 1'b0;
    end
    @(negedge clk);
    chk("upd_acs_en", acs_en, 0);
    chk("upd_surv_wr_en", surv_wr_en, 0);
    chk("upd_in_ready", in_ready, 0);
    chk("upd_rx_pair", rx_pair, pair);
    tb_ack = 1'b0;
    min_pm = 8'($urandom);
    fe = ((m_sym % FRAME_LEN) == FRAME_LEN - 1);
    m_sym++;
    m_bank     = ~m_bank;
    m_norm_en  = (int'(lo) >= THRESH);
    m_norm_sub = m_norm_en ? lo : 8'd0;
    if (fe) begin
      @(negedge clk);
      chk("tbreq_rise", tb_req, 1);
      chk("tbreq_in_ready", in_ready, 0);
      chk("tbreq_bank", pm_rd_bank, m_bank);
      for (int d = 0; d < ack_dly; d++) begin
        @(negedge clk);
        chk("tbreq_hold", tb_req, 1);
        chk("tbreq_hold_in_ready", in_ready, 0);
        chk("tbreq_rx_pair", rx_pair, pair);
      end
      tb_ack = 1'b1;
      @(negedge clk);
      tb_ack = 1'b0;
      chk("tbreq_drop", tb_req, 0);
      chk("tbreq_idle", in_ready, 1);
    end
  endtask

  task automatic rand_mins(output mins_t m);
    for (int k = 0; k < G; k++) m[k] = 8'($urandom_range(110, 255));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    mins_t m;
    int    gap;
    int    nxt_gap;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_pair  = 2'b00;
    min_pm   = 8'd0;
    tb_ack   = 1'b0;
    b2b_chk  = 1'b0;
    last_acc = 0;
    model_reset();

    tbl[0] = '{pair: 2'b10, mins: mk(130, 129, 140, 128), en: 1'b1, sub: 8'd128};
    tbl[1] = '{pair: 2'b01, mins: mk(127, 200, 200, 200), en: 1'b0, sub: 8'd0};
    tbl[2] = '{pair: 2'b11, mins: mk(255, 255, 255, 255), en: 1'b1, sub: 8'd255};
    tbl[3] = '{pair: 2'b00, mins: mk(200, 0, 200, 200),   en: 1'b0, sub: 8'd0};
    tbl[4] = '{pair: 2'b01, mins: mk(129, 131, 250, 128), en: 1'b1, sub: 8'd128};
    tbl[5] = '{pair: 2'b10, mins: mk(128, 128, 128, 127), en: 1'b0, sub: 8'd0};

    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_acs_en", acs_en, 0);
    chk("rst_bank", pm_rd_bank, 0);
    chk("rst_tb_req", tb_req, 0);
    chk("rst_norm_en", norm_en, 0);
    chk("rst_rx_pair", rx_pair, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Table vectors; normalization outcome checked in the following IDLE cycle.
    foreach (tbl[i]) begin
      run_symbol(tbl[i].pair, tbl[i].mins, 1'b0, 1'b1, 0);
      @(negedge clk);
      chk("tbl_norm_en", norm_en, tbl[i].en);
      chk("tbl_norm_sub", norm_sub, tbl[i].sub);
      chk("tbl_bank", pm_rd_bank, (i + 1) % 2);
      chk("tbl_idle_ready", in_ready, 1);
    end

    // Spurious ack and stray min_pm in IDLE must not move the scheduler.
    tb_ack = 1'b1;
    min_pm = 8'd3;
    repeat (3) begin
      @(negedge clk);
      chk("spur_idle_ready", in_ready, 1);
      chk("spur_idle_tb_req", tb_req, 0);
      chk("spur_idle_acs_en", acs_en, 0);
    end
    tb_ack = 1'b0;

    // Back-to-back with in_valid held high: one symbol per G+2 cycles.
    b2b_chk = 1'b1;
    have_last = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rand_mins(m);
      run_symbol(2'(i), m, (i != 4), 1'b0, 0);
    end
    b2b_chk = 1'b0;

    // Run through the frame end with a long traceback stall.
    do begin
      rand_mins(m);
      run_symbol(2'($urandom), m, 1'b0, 1'b0, 10);
    end while ((m_sym % FRAME_LEN) != 0);
    rand_mins(m);
    run_symbol(2'b11, m, 1'b0, 1'b0, 0);

    // Reset in the middle of RUN with normalization pending.
    @(negedge clk);
    run_symbol(2'b01, mk(200, 220, 230, 240), 1'b0, 1'b0, 0);
    @(negedge clk);
    chk("pre_rst_norm_en", norm_en, 1);
    in_pair  = 2'b10;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_grp_idx", grp_idx, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_acs_en", acs_en, 0);
    chk("mid_rst_tb_req", tb_req, 0);
    chk("mid_rst_norm_en", norm_en, 0);
    chk("mid_rst_norm_sub", norm_sub, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_bank", pm_rd_bank, 0);
    chk("mid_rst_surv_wr_en", surv_wr_en, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    run_symbol(2'b11, mk(10, 20, 30, 40), 1'b0, 1'b0, 0);

    // Randomized stream with gaps, spurious acks and random traceback latency.
    nxt_gap = $urandom_range(0, 3);
    for (int i = 0; i < 120; i++) begin
      gap = nxt_gap;
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        chk("rand_gap_ready", in_ready, 1);
        chk("rand_gap_acs_en", acs_en, 0);
        tb_ack = 1'($urandom);
      end
      nxt_gap = $urandom_range(0, 3);
      rand_mins(m);
      run_symbol(2'($urandom), m, (nxt_gap == 0), 1'b1, $urandom_range(0, 5));
    end
    in_valid = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
